// File: rtl/tag_tree_pipe_ctrl.sv
// Issue/flow controller for the multibit-tree tag-sort pipeline: arbitrates insert vs search,
// drives per-stage enables, shadows valid/op per stage and presents the last-stage result.
module tag_tree_pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 12,
  localparam int CNT_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ins_valid,
  input  logic [TAG_W-1:0]      ins_tag,
  output logic                  ins_ready,
  input  logic                  srch_valid,
  input  logic [TAG_W-1:0]      srch_tag,
  output logic                  srch_ready,
  input  logic                  flush,
  output logic [TAG_W-1:0]      issue_tag,
  output logic                  issue_op,
  output logic [NUM_STAGES-1:0] stage_ena,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  res_valid,
  output logic                  res_op,
  input  logic                  res_ready,
  input  logic                  not_found_in,
  output logic                  res_not_found,
  output logic [CNT_W-1:0]      inflight_cnt
);

  logic [NUM_STAGES-1:0] vld_p;
  logic [NUM_STAGES-1:0] op_p;
  logic [NUM_STAGES-1:0] ena;
  logic                  last_grant;  // 0 = search, 1 = insert
  logic [CNT_W-1:0]      cnt;
  logic                  ins_inflight, ins_elig, srch_elig;
  logic                  grant_ins, grant_srch, fire, retire;

  // Enable chain built from the last stage backward so bubbles collapse under a stall
  always_comb begin
    logic nxt;
    ena = '0;
    nxt = !vld_p[NUM_STAGES-1] | res_ready;
    ena[NUM_STAGES-1] = nxt;
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      nxt    = !vld_p[k] | nxt;
      ena[k] = nxt;
    end
  end

  always_comb begin
    ins_inflight = |(vld_p & op_p);
    ins_elig     = ins_valid & ena[0];
    srch_elig    = srch_valid & ena[0] & !ins_inflight;
    grant_ins    = !flush & ins_elig & (!srch_elig | !last_grant);
    grant_srch   = !flush & srch_elig & (!ins_elig | last_grant);
    fire         = grant_ins | grant_srch;
    retire       = vld_p[NUM_STAGES-1] & res_ready & !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p      <= '0;
      op_p       <= '0;
      last_grant <= 1'b0;
      cnt        <= '0;
    end else begin
      if (ena[0]) op_p[0] <= grant_ins;
      for (int k = 1; k < NUM_STAGES; k++)
        if (ena[k]) op_p[k] <= op_p[k-1];
      if (fire) last_grant <= grant_ins;
      if (flush) begin
        vld_p <= '0;
        cnt   <= '0;
      end else begin
        if (ena[0]) vld_p[0] <= fire;
        for (int k = 1; k < NUM_STAGES; k++)
          if (ena[k]) vld_p[k] <= vld_p[k-1];
        case ({fire, retire})
          2'b10:   cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          2'b01:   cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign ins_ready     = grant_ins;
  assign srch_ready    = grant_srch;
  assign issue_op      = grant_ins;
  assign issue_tag     = grant_ins ? ins_tag : (grant_srch ? srch_tag : '0);
  assign stage_ena     = ena;
  assign stage_valid   = vld_p;
  assign res_valid     = vld_p[NUM_STAGES-1];
  assign res_op        = op_p[NUM_STAGES-1];
  assign res_not_found = vld_p[NUM_STAGES-1] & not_found_in;
  assign inflight_cnt  = cnt;

endmodule

// File: tb/tb_tag_tree_pipe_ctrl.sv
// Directed bench for tag_tree_pipe_ctrl with hand-computed expectations at NUM_STAGES=4.
module tb_tag_tree_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid, srch_valid, flush, res_ready, not_found_in;
  logic [11:0] ins_tag, srch_tag, issue_tag;
  logic        ins_ready, srch_ready, issue_op, res_valid, res_op, res_not_found;
  logic [3:0]  stage_ena, stage_valid;
  logic [2:0]  inflight_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tag_tree_pipe_ctrl #(.NUM_STAGES(4), .TAG_W(12)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_tag(ins_tag), .ins_ready(ins_ready),
    .srch_valid(srch_valid), .srch_tag(srch_tag), .srch_ready(srch_ready),
    .flush(flush), .issue_tag(issue_tag), .issue_op(issue_op),
    .stage_ena(stage_ena), .stage_valid(stage_valid),
    .res_valid(res_valid), .res_op(res_op), .res_ready(res_ready),
    .not_found_in(not_found_in), .res_not_found(res_not_found),
    .inflight_cnt(inflight_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ins_valid = 0; srch_valid = 0; flush = 0; res_ready = 0; not_found_in = 0;
    ins_tag = '0; srch_tag = '0;
    do_reset();
    #1;
    check("rst_stage_valid", stage_valid, 4'b0000);
    check("rst_res_valid", res_valid, 0);
    check("rst_inflight", inflight_cnt, 0);
    check("rst_ins_ready", ins_ready, 0);
    check("rst_srch_ready", srch_ready, 0);
    check("rst_issue_tag", issue_tag, 0);
    check("rst_stage_ena", stage_ena, 4'b1111);

    // single insert walks the pipe
    ins_valid = 1; ins_tag = 12'hA53; res_ready = 1;
    #1;
    check("t1_ins_ready", ins_ready, 1);
    check("t1_issue_tag", issue_tag, 12'hA53);
    check("t1_issue_op", issue_op, 1);
    tick(); ins_valid = 0; #1;
    check("t1_sv_c1", stage_valid, 4'b0001);
    check("t1_cnt_c1", inflight_cnt, 1);
    tick();
    check("t1_sv_c2", stage_valid, 4'b0010);
    tick();
    check("t1_sv_c3", stage_valid, 4'b0100);
    check("t1_resv_c3", res_valid, 0);
    tick();
    check("t1_sv_c4", stage_valid, 4'b1000);
    check("t1_resv_c4", res_valid, 1);
    check("t1_resop_c4", res_op, 1);
    tick();
    check("t1_sv_c5", stage_valid, 4'b0000);
    check("t1_cnt_c5", inflight_cnt, 0);

    // arbitration and read-after-write hazard
    do_reset();
    ins_valid = 1; srch_valid = 1; ins_tag = 12'h111; srch_tag = 12'h222; res_ready = 1;
    #1;
    check("t2_ins_first", ins_ready, 1);
    check("t2_srch_held0", srch_ready, 0);
    tick(); ins_valid = 0; #1;
    check("t2_srch_blk_c1", srch_ready, 0);
    tick(); tick(); tick();
    check("t2_resv_c4", res_valid, 1);
    check("t2_srch_blk_c4", srch_ready, 0);
    tick(); ins_valid = 1; #1;
    check("t2_srch_c5", srch_ready, 1);
    check("t2_ins_c5", ins_ready, 0);
    check("t2_issue_op_c5", issue_op, 0);
    check("t2_issue_tag_c5", issue_tag, 12'h222);
    tick();
    check("t2_ins_c6", ins_ready, 1);
    check("t2_srch_c6", srch_ready, 0);
    tick(); ins_valid = 0; srch_valid = 0;
    repeat (5) tick();
    check("t2_drained", inflight_cnt, 0);

    // fill with searches under stall
    res_ready = 0; srch_valid = 1; srch_tag = 12'h3C7;
    #1;
    check("t3_srch_c0", srch_ready, 1);
    check("t3_tag_c0", issue_tag, 12'h3C7);
    tick(); tick(); tick();
    check("t3_srch_c3", srch_ready, 1);
    tick();
    check("t3_sv_c4", stage_valid, 4'b1111);
    check("t3_cnt_c4", inflight_cnt, 4);
    check("t3_srch_c4", srch_ready, 0);
    check("t3_ena_c4", stage_ena, 4'b0000);
    check("t3_resop_c4", res_op, 0);
    tick();
    check("t3_sv_c5", stage_valid, 4'b1111);
    res_ready = 1; #1;
    check("t3_ena_rr", stage_ena, 4'b1111);
    check("t3_srch_rr", srch_ready, 1);
    tick(); res_ready = 0; srch_valid = 0; #1;
    check("t3_cnt_after", inflight_cnt, 4);
    check("t3_sv_after", stage_valid, 4'b1111);
    res_ready = 1;
    repeat (4) tick();
    check("t3_drained", inflight_cnt, 0);

    // bubble collapse, then not_found qualification
    res_ready = 0; srch_valid = 1;
    tick(); srch_valid = 0;
    tick(); tick(); srch_valid = 1;
    tick(); srch_valid = 0; #1;
    check("t4_sv_c4", stage_valid, 4'b1001);
    check("t4_ena_c4", stage_ena, 4'b0111);
    tick();
    check("t4_sv_c5", stage_valid, 4'b1010);
    tick();
    check("t4_sv_c6", stage_valid, 4'b1100);
    check("t4_ena_c6", stage_ena, 4'b0011);
    tick();
    check("t4_sv_c7", stage_valid, 4'b1100);
    not_found_in = 1; #1;
    check("t5_nf_valid", res_not_found, 1);
    res_ready = 1;
    tick();
    check("t5_sv_mid", stage_valid, 4'b1000);
    check("t5_nf_mid", res_not_found, 1);
    tick();
    check("t5_resv_after", res_valid, 0);
    check("t5_nf_after", res_not_found, 0);
    not_found_in = 0;

    // flush with three live ops
    res_ready = 0; srch_valid = 1;
    tick(); tick(); tick(); srch_valid = 0; #1;
    check("t6_sv_pre", stage_valid, 4'b0111);
    check("t6_cnt_pre", inflight_cnt, 3);
    flush = 1; ins_valid = 1; srch_valid = 1; #1;
    check("t6_ins_flush", ins_ready, 0);
    check("t6_srch_flush", srch_ready, 0);
    tick(); flush = 0; ins_valid = 0; srch_valid = 0; #1;
    check("t6_sv_post", stage_valid, 4'b0000);
    check("t6_cnt_post", inflight_cnt, 0);
    check("t6_resv_post", res_valid, 0);

    // reset mid-pipe, then a clean insert
    ins_valid = 1; ins_tag = 12'h5A5; #1;
    check("t7_ins_fire", ins_ready, 1);
    tick(); ins_valid = 0;
    tick(); #1;
    check("t7_sv_mid", stage_valid, 4'b0010);
    do_reset(); #1;
    check("t7_sv_rst", stage_valid, 4'b0000);
    check("t7_cnt_rst", inflight_cnt, 0);
    res_ready = 1; ins_valid = 1; ins_tag = 12'h0F0; #1;
    check("t7_ins_c0", ins_ready, 1);
    tick(); ins_valid = 0;
    tick(); tick();
    check("t7_resv_c3", res_valid, 0);
    tick();
    check("t7_resv_c4", res_valid, 1);
    check("t7_resop_c4", res_op, 1);
    check("t7_sv_c4", stage_valid, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
